// File: rtl/rr_grant_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rr_grant_arbiter_pkg
//  Brief    : Shared state codes, defaults and helpers for round-robin arbiters
//  Revision : 1.0  initial release
// ============================================================================
package rr_grant_arbiter_pkg;

    // The state code doubles as the owner encoding (0 = none, 1..3 = grantee)
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_GNT1 = 2'b01,
        ST_GNT2 = 2'b10,
        ST_GNT3 = 2'b11
    } arb_state_e;

    localparam int MAX_HOLD_DEF = 8;
    localparam int HOLD_W_DEF   = 3;

    // Rotating pointer successor in 1-based modulo-3 arithmetic (3 wraps to 1)
    function automatic logic [1:0] ptr_after(input logic [1:0] k);
        return (k == 2'd3) ? 2'd1 : k + 2'd1;
    endfunction

    // One-hot grant vector for an owner code; bit 0 corresponds to requester 1
    function automatic logic [2:0] owner_onehot(input logic [1:0] own);
        logic [2:0] v;
        v = 3'b000;
        case (own)
            2'd1:    v = 3'b001;
            2'd2:    v = 3'b010;
            2'd3:    v = 3'b100;
            default: v = 3'b000;
        endcase
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_grant_arbiter_hold_timer.sv
`default_nettype none
// ============================================================================
//  Module   : rr_grant_arbiter_hold_timer
//  Brief    : Saturating hold counter; stores (grant cycles - 1) so that a
//             HOLD_W field with 2**HOLD_W >= MAX_HOLD is always wide enough
//  Revision : 1.0  initial release
// ============================================================================
module rr_grant_arbiter_hold_timer #(
    parameter int MAX_HOLD = 8,
    parameter int HOLD_W   = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic at_max_o
);

    localparam logic [HOLD_W-1:0] LAST = HOLD_W'(MAX_HOLD - 1);

    logic [HOLD_W-1:0] cnt_q;
    logic [HOLD_W-1:0] cnt_d;

    // Clear wins over count; the count saturates at the last permitted cycle
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != LAST)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_max_o = (cnt_q == LAST);

endmodule
`default_nettype wire

// File: rtl/rr_grant_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rr_grant_arbiter
//  Brief    : Three-requester round-robin arbiter with bounded grant hold time;
//             all outputs registered, grants one-hot or zero
//  Revision : 1.0  initial release
// ============================================================================
module rr_grant_arbiter
    import rr_grant_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = MAX_HOLD_DEF,
    parameter int HOLD_W   = HOLD_W_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] r_i,
    output logic [2:0] g_o,
    output logic       busy_o,
    output logic       timeout_o,
    output logic [1:0] owner_o
);

    arb_state_e state_q, state_d;
    logic [1:0] ptr_q, ptr_d;
    logic [1:0] pick;
    logic       timeout_d;
    logic       tmr_clr;
    logic       tmr_en;
    logic       tmr_at_max;
    logic [1:0] cur_k;
    logic [2:0] g_q;
    logic       busy_q;
    logic       timeout_q;
    logic [1:0] owner_q;

    rr_grant_arbiter_hold_timer #(
        .MAX_HOLD (MAX_HOLD),
        .HOLD_W   (HOLD_W)
    ) u_hold_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (tmr_clr),
        .en_i     (tmr_en),
        .at_max_o (tmr_at_max)
    );

    // Priority scan from ptr; iterate furthest-first so the nearest hit wins
    always_comb begin
        pick = 2'd0;
        for (int i = 2; i >= 0; i--) begin
            int idx;
            idx = (int'(ptr_q) - 1 + i) % 3;
            if (r_i[idx]) begin
                pick = 2'(idx + 1);
            end
        end
    end

    // Next-state, pointer update, hold-timer control and revoke detection
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        timeout_d = 1'b0;
        tmr_clr   = 1'b1;
        tmr_en    = 1'b0;
        cur_k     = 2'(state_q);
        case (state_q)
            ST_IDLE: begin
                if (r_i != 3'b000) begin
                    state_d = arb_state_e'(pick);
                end
            end
            ST_GNT1, ST_GNT2, ST_GNT3: begin
                if (!r_i[cur_k - 2'd1]) begin
                    // Voluntary release takes precedence over an expiring hold
                    state_d = ST_IDLE;
                    ptr_d   = ptr_after(cur_k);
                end else if (tmr_at_max) begin
                    state_d   = ST_IDLE;
                    ptr_d     = ptr_after(cur_k);
                    timeout_d = 1'b1;
                end else begin
                    tmr_clr = 1'b0;
                    tmr_en  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, pointer and registered outputs derived from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            ptr_q     <= 2'd1;
            g_q       <= 3'b000;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
            owner_q   <= 2'd0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            g_q       <= owner_onehot(2'(state_d));
            busy_q    <= (state_d != ST_IDLE);
            timeout_q <= timeout_d;
            owner_q   <= 2'(state_d);
        end
    end

    assign g_o       = g_q;
    assign busy_o    = busy_q;
    assign timeout_o = timeout_q;
    assign owner_o   = owner_q;

endmodule
`default_nettype wire

// File: tb/tb_rr_grant_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rr_grant_arbiter
//  Brief    : Self-checking bench for rr_grant_arbiter against a cycle model
//  Revision : 1.0  initial release
// ============================================================================
module tb_rr_grant_arbiter;

    localparam int MAXH = 8;

    logic       clk;
    logic       rst_n;
    logic [2:0] r;
    logic [2:0] g;
    logic       busy;
    logic       timeout;
    logic [1:0] owner;

    int checks = 0;
    int errors = 0;

    // Reference model: current owner (0 none), pointer 1..3, cycles held, timeout flag
    int m_owner;
    int m_ptr;
    int m_cnt;
    int m_to;

    rr_grant_arbiter #(.MAX_HOLD(MAXH), .HOLD_W(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .r_i       (r),
        .g_o       (g),
        .busy_o    (busy),
        .timeout_o (timeout),
        .owner_o   (owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = 0;
        m_ptr   = 1;
        m_cnt   = 0;
        m_to    = 0;
    endtask

    // One clock of arbitration rules applied to the request vector seen at the edge
    task automatic model_step(input logic [2:0] rv);
        int k;
        m_to = 0;
        if (m_owner == 0) begin
            for (int i = 0; i < 3; i++) begin
                k = ((m_ptr - 1 + i) % 3) + 1;
                if (m_owner == 0 && rv[k-1]) begin
                    m_owner = k;
                    m_cnt   = 1;
                end
            end
        end else begin
            k = m_owner;
            if (!rv[k-1] || m_cnt == MAXH) begin
                m_to    = rv[k-1] ? 1 : 0;
                m_owner = 0;
                m_cnt   = 0;
                m_ptr   = (k % 3) + 1;
            end else begin
                m_cnt = m_cnt + 1;
            end
        end
    endtask

    function automatic int exp_g();
        return (m_owner == 0) ? 0 : (1 << (m_owner - 1));
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".g"},       int'(g),       exp_g());
        chk({tag, ".busy"},    int'(busy),    (m_owner != 0) ? 1 : 0);
        chk({tag, ".owner"},   int'(owner),   m_owner);
        chk({tag, ".timeout"}, int'(timeout), m_to);
    endtask

    // Apply r, advance one clock, update model, sample 1 ns after the edge
    task automatic step(input logic [2:0] rv, input string tag);
        r = rv;
        @(posedge clk);
        model_step(rv);
        #1;
        check_all(tag);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #3;
        chk("rst.g",       int'(g),       0);
        chk("rst.busy",    int'(busy),    0);
        chk("rst.owner",   int'(owner),   0);
        chk("rst.timeout", int'(timeout), 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [2:0] rr;
    int         saw100;

    initial begin
        r = 3'b000;
        rst_n = 1'b1;
        model_reset();
        #2;
        do_reset();

        // Reset mid-grant drops everything at once, then a fresh grant in one clock
        step(3'b010, "t1.gnt2");
        chk("t1.g010", int'(g), 3'b010);
        step(3'b010, "t1.hold");
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("t1.async_g",     int'(g),     0);
        chk("t1.async_busy",  int'(busy),  0);
        chk("t1.async_owner", int'(owner), 0);
        @(negedge clk);
        rst_n = 1'b1;
        step(3'b010, "t1.regrant");
        chk("t1.regrant_g", int'(g), 3'b010);

        // Single requester: grant latency 1, release latency 1
        do_reset();
        step(3'b001, "t2.c1");
        chk("t2.g_c1", int'(g), 3'b001);
        step(3'b001, "t2.c2");
        step(3'b001, "t2.c3");
        step(3'b001, "t2.c4");
        step(3'b000, "t2.c5");
        chk("t2.g_c5", int'(g), 0);

        // Contention with all three holding: bounded grants and fair rotation
        do_reset();
        for (int c = 1; c <= 3 * (MAXH + 1) + 1; c++) begin
            step(3'b111, "t3.all");
            if (c == MAXH + 1) begin
                chk("t3.first_timeout", int'(timeout), 1);
                chk("t3.first_gap_g",   int'(g),       0);
            end
            if (c == MAXH + 2) chk("t3.second_g", int'(g), 3'b010);
            if (c == 3 * (MAXH + 1) + 1) chk("t3.wrap_g", int'(g), 3'b001);
        end
        step(3'b000, "t3.drain");
        step(3'b000, "t3.idle");

        // Rotation: after r1 is served, r2 beats r1
        do_reset();
        step(3'b001, "t4.g1");
        step(3'b000, "t4.rel");
        step(3'b011, "t4.rot");
        chk("t4.rot_g", int'(g), 3'b010);
        step(3'b000, "t4.rel2");
        step(3'b000, "t4.idle");

        // Release exactly when the hold limit is reached: no timeout
        do_reset();
        for (int c = 1; c <= MAXH; c++) step(3'b001, "t5.hold");
        step(3'b000, "t5.rel_at_max");
        chk("t5.no_timeout", int'(timeout), 0);
        // Sole requester revoked, then re-granted after one idle cycle
        for (int c = 1; c <= MAXH + 1; c++) step(3'b100, "t5.sole");
        chk("t5.revoke_g",  int'(g),       0);
        chk("t5.revoke_to", int'(timeout), 1);
        step(3'b100, "t5.regrant");
        chk("t5.regrant_g", int'(g), 3'b100);
        step(3'b000, "t5.rel");
        step(3'b000, "t5.idle");

        // Requests raised and dropped during another grant are not latched
        do_reset();
        saw100 = 0;
        step(3'b001, "t6.g1");
        step(3'b101, "t6.r3up");
        if (g == 3'b100) saw100 = 1;
        step(3'b101, "t6.r3up2");
        if (g == 3'b100) saw100 = 1;
        step(3'b001, "t6.r3dn");
        if (g == 3'b100) saw100 = 1;
        step(3'b000, "t6.rel");
        if (g == 3'b100) saw100 = 1;
        step(3'b000, "t6.idle");
        if (g == 3'b100) saw100 = 1;
        chk("t6.never_g3", saw100, 0);

        // Randomised traffic; requests mostly persist to exercise hold limits
        do_reset();
        rr = 3'b000;
        for (int c = 0; c < 400; c++) begin
            for (int b = 0; b < 3; b++) begin
                if ($urandom_range(0, 9) < 2) rr[b] = ~rr[b];
            end
            step(rr, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
